sigmoid_backward: RTL and testbench

Backward-pass companion to the forward sigmoid unit. It computes the local gradient delta = g · s · (1 − s) in IEEE-754 float32, where s is the value the forward sigmoid produced and g is the upstream gradient. A multi-cycle FSM time-shares one float adder core and one float multiplier core, and a valid/ready handshake connects it to the training controller. The block sits between the forward-activation store and the weight-update datapath of the XOR network.

---
 rtl/sigmoid_backward.sv | 259 +++++++++++++++++++++++++
 tb/tb_sigmoid_backward.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_backward.sv
// ============================================================================
//  Module   : sigmoid_backward (with float32 cores add / mult)
//  Purpose  : delta = g * s * (1 - s) on one shared adder and one shared
//             multiplier. Optional macro SIGMOID_BWD_FTZ_EN flushes subnormal
//             results to signed zero at the output register.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sigmoid_bwd_pkg;
  localparam logic [31:0] c_QNAN = 32'h7FC0_0000;

  // man holds the exact magnitude; an MSB at bit 49 means biased exponent expIn.
  function automatic logic [31:0] roundPack(input logic sign,
                                            input logic signed [11:0] expIn,
                                            input logic [49:0] manIn);
    logic [49:0]        man;
    logic signed [11:0] expV;
    logic [5:0]         lz;
    logic [11:0]        sh;
    logic [24:0]        rnd;
    logic               guardBit;
    logic               stickyBit;
    lz = '0;
    for (int i = 0; i < 50; i++)
      if (manIn[i]) lz = 6'(49 - i);
    man  = manIn << lz;
    expV = expIn - $signed({6'd0, lz});
    if (expV < 12'sd1) begin
      sh = 12'(12'sd1 - expV);
      if (sh > 12'd49) man = {49'd0, |man};
      else             man = (man >> sh) | {49'd0, |(man & ~({50{1'b1}} << sh))};
      expV = 12'sd1;
    end
    guardBit  = man[25];
    stickyBit = |man[24:0];
    rnd = {1'b0, man[49:26]} + {24'd0, guardBit & (stickyBit | man[26])};
    if (rnd[24]) begin
      rnd  = rnd >> 1;
      expV = expV + 12'sd1;
    end
    if (expV >= 12'sd255) roundPack = {sign, 8'hFF, 23'd0};
    else                  roundPack = {sign, rnd[23] ? expV[7:0] : 8'h00, rnd[22:0]};
  endfunction

  function automatic logic [31:0] fAdd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  eHi;
    logic [7:0]  eLo;
    logic [7:0]  d;
    logic [49:0] mHi;
    logic [49:0] mLo;
    logic [49:0] mSum;
    logic        aNan, bNan, aInf, bInf;
    aNan = (&a[30:23]) && (|a[22:0]);
    bNan = (&b[30:23]) && (|b[22:0]);
    aInf = (&a[30:23]) && !(|a[22:0]);
    bInf = (&b[30:23]) && !(|b[22:0]);
    if (aNan || bNan)      fAdd = c_QNAN;
    else if (aInf && bInf) fAdd = (a[31] == b[31]) ? a : c_QNAN;
    else if (aInf)         fAdd = a;
    else if (bInf)         fAdd = b;
    else begin
      if (a[30:0] >= b[30:0]) begin hi = a; lo = b; end
      else                    begin hi = b; lo = a; end
      eHi = (hi[30:23] == 8'd0) ? 8'd1 : hi[30:23];
      eLo = (lo[30:23] == 8'd0) ? 8'd1 : lo[30:23];
      d   = eHi - eLo;
      mHi = {1'b0, |hi[30:23], hi[22:0], 25'd0};
      mLo = {1'b0, |lo[30:23], lo[22:0], 25'd0};
      if (d > 8'd49) mLo = {49'd0, |mLo};
      else           mLo = (mLo >> d) | {49'd0, |(mLo & ~({50{1'b1}} << d))};
      mSum = (hi[31] == lo[31]) ? mHi + mLo : mHi - mLo;
      if (mSum == 50'd0) fAdd = {hi[31] & lo[31], 31'd0};
      else               fAdd = roundPack(hi[31], $signed({4'd0, eHi}) + 12'sd1, mSum);
    end
  endfunction

  function automatic logic [31:0] fMul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic        aNan, bNan, aInf, bInf, aZero, bZero;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [47:0] prod;
    sgn   = a[31] ^ b[31];
    aNan  = (&a[30:23]) && (|a[22:0]);
    bNan  = (&b[30:23]) && (|b[22:0]);
    aInf  = (&a[30:23]) && !(|a[22:0]);
    bInf  = (&b[30:23]) && !(|b[22:0]);
    aZero = (a[30:0] == 31'd0);
    bZero = (b[30:0] == 31'd0);
    if (aNan || bNan)                           fMul = c_QNAN;
    else if ((aInf && bZero) || (bInf && aZero)) fMul = c_QNAN;
    else if (aInf || bInf)                      fMul = {sgn, 8'hFF, 23'd0};
    else if (aZero || bZero)                    fMul = {sgn, 31'd0};
    else begin
      ea   = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
      eb   = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
      prod = 48'({|a[30:23], a[22:0]}) * 48'({|b[30:23], b[22:0]});
      fMul = roundPack(sgn, $signed({4'd0, ea}) + $signed({4'd0, eb}) - 12'sd126,
                       {prod, 2'b00});
    end
  endfunction
endpackage

// Float32 adder: result appears LAT clock edges after the operands are sampled.
module add #(
  parameter int LAT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  import sigmoid_bwd_pkg::*;
  logic [LAT-1:0][31:0] r_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pipe <= '0;
    else begin
      r_pipe[0] <= fAdd(a, b);
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign y = r_pipe[LAT-1];
endmodule

// Float32 multiplier: result appears LAT clock edges after the operands are sampled.
module mult #(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  import sigmoid_bwd_pkg::*;
  logic [LAT-1:0][31:0] r_pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pipe <= '0;
    else begin
      r_pipe[0] <= fMul(a, b);
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign y = r_pipe[LAT-1];
endmodule

module sigmoid_backward #(
  parameter int ADD_LAT = 7,
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s_in,
  input  logic [31:0] g_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);
  localparam int c_MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
  localparam int c_CNT_W   = $clog2(c_MAX_LAT) + 1;
  localparam logic [31:0]        c_ONE      = 32'h3F80_0000;
  localparam logic [c_CNT_W-1:0] c_SUB_LOAD = c_CNT_W'(ADD_LAT - 1);
  localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT);

  typedef enum logic [2:0] {IDLE, SUB, MUL1, MUL2, DONE} stateT;

  stateT               r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [31:0]         r_s, r_g, r_oms, r_p;
  logic [31:0]         w_addB, w_addY, w_mulA, w_mulB, w_mulY, w_result;

  // The adder samples the flipped operand on the accept edge itself, so the
  // subtraction wait is one cycle shorter than the multiply waits.
  assign w_addB = (r_state == IDLE) ? {~s_in[31], s_in[30:0]} : {~r_s[31], r_s[30:0]};
  assign w_mulA = (r_state == MUL1) ? r_s   : r_p;
  assign w_mulB = (r_state == MUL1) ? r_oms : r_g;

  add #(.LAT(ADD_LAT)) u_add (
    .clk(clk), .rst(rst), .a(c_ONE), .b(w_addB), .y(w_addY)
  );

  mult #(.LAT(MUL_LAT)) u_mult (
    .clk(clk), .rst(rst), .a(w_mulA), .b(w_mulB), .y(w_mulY)
  );

`ifdef SIGMOID_BWD_FTZ_EN
  assign w_result = ((w_mulY[30:23] == 8'd0) && (|w_mulY[22:0])) ? {w_mulY[31], 31'd0} : w_mulY;
`else
  assign w_result = w_mulY;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_s       <= '0;
      r_g       <= '0;
      r_oms     <= '0;
      r_p       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            r_s      <= s_in;
            r_g      <= g_in;
            r_cnt    <= c_SUB_LOAD;
            in_ready <= 1'b0;
            r_state  <= SUB;
          end
        end
        SUB: begin
          if (r_cnt == '0) begin
            r_oms   <= w_addY;
            r_cnt   <= c_MUL_LOAD;
            r_state <= MUL1;
          end else r_cnt <= r_cnt - 1'b1;
        end
        MUL1: begin
          if (r_cnt == '0) begin
            r_p     <= w_mulY;
            r_cnt   <= c_MUL_LOAD;
            r_state <= MUL2;
          end else r_cnt <= r_cnt - 1'b1;
        end
        MUL2: begin
          if (r_cnt == '0) begin
            out_data  <= w_result;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end else r_cnt <= r_cnt - 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_sigmoid_backward.sv
// ============================================================================
//  Module   : tb_sigmoid_backward
//  Purpose  : directed and random checks of sigmoid_backward against a
//             real-arithmetic reference with float32 rounding.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sigmoid_backward;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] s_in;
  logic [31:0] g_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sigmoid_backward dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .s_in(s_in), .g_in(g_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic real toReal(input logic [31:0] f);
    int  e;
    real m;
    real scale;
    e     = (f[30:23] == 8'd0) ? 1 : int'(f[30:23]);
    m     = real'(f[22:0]) + ((f[30:23] != 8'd0) ? 8388608.0 : 0.0);
    scale = $bitstoreal({1'b0, 11'(e - 150 + 1023), 52'd0});
    return f[31] ? -(m * scale) : m * scale;
  endfunction

  // Round-to-nearest-even of a double into float32, subnormals included.
  function automatic logic [31:0] toF32(input real x);
    logic [63:0] b;
    logic [63:0] mant;
    logic [63:0] q;
    logic [63:0] rem;
    logic [63:0] half;
    int          e;
    int          sh;
    if (x == 0.0) return 32'h0;
    b    = $realtobits(x);
    e    = int'(b[62:52]) - 1023 + 127;
    mant = {11'd0, 1'b1, b[51:0]};
    sh   = 29 + ((e < 1) ? (1 - e) : 0);
    if (sh > 62) return {b[63], 31'd0};
    q    = mant >> sh;
    rem  = mant & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (e < 1) return {b[63], q[23] ? 8'd1 : 8'd0, q[22:0]};
    if (q[24]) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {b[63], 8'hFF, 23'd0};
    return {b[63], 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] refDelta(input logic [31:0] s, input logic [31:0] g);
    logic [31:0] oms;
    logic [31:0] p;
    logic [31:0] d;
    oms = toF32(1.0 - toReal(s));
    p   = toF32(toReal(s) * toReal(oms));
    d   = toF32(toReal(p) * toReal(g));
`ifdef SIGMOID_BWD_FTZ_EN
    if (d[30:23] == 8'd0 && d[22:0] != 23'd0) d = {d[31], 31'd0};
`endif
    return d;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic waitReady(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic accept(input logic [31:0] s, input logic [31:0] g);
    s_in = s; g_in = g; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    s_in = $urandom; g_in = $urandom;
  endtask

  // Issues one operation, checks latency and result; handshakes if out_ready=1.
  task automatic doOp(input logic [31:0] s, input logic [31:0] g, input string tag,
                      output logic [31:0] res);
    int lat = 0;
    waitReady(tag);
    accept(s, g);
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd19);
    res = out_data;
    check({tag, " data"}, out_data, refDelta(s, g));
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, " ready after handshake"}, {31'd0, in_ready}, 32'd1);
      check({tag, " valid dropped"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    logic [31:0] s;
    logic [31:0] g;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; s_in = '0; g_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", {31'd0, in_ready}, 32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_data", out_data, 32'd0);
    rst = 1'b0;

    doOp(32'h3F00_0000, 32'h3F80_0000, "half", res);
    check("half const", res, 32'h3E80_0000);
    doOp(32'h3F40_0000, 32'hC000_0000, "three quarters", res);
    check("three quarters const", res, 32'hBEC0_0000);
    doOp(32'h3F80_0000, 32'h3F80_0000, "s one", res);
    check("s one const", res, 32'h0000_0000);
    doOp(32'h0000_0000, 32'h3F80_0000, "s zero", res);
    check("s zero const", res, 32'h0000_0000);

    // Backpressure held in DONE for ten cycles.
    out_ready = 1'b0;
    doOp(32'h3F20_0000, 32'h4040_0000, "backpressure", held);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp data hold", out_data, held);
      check("bp valid hold", {31'd0, out_valid}, 32'd1);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    check("bp release valid", {31'd0, out_valid}, 32'd0);
    doOp(32'h3E80_0000, 32'hBF80_0000, "after bp", res);

    // Reset in the middle of an operation.
    waitReady("midreset");
    accept(32'h3F40_0000, 32'h4000_0000);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset out_data", out_data, 32'd0);
    check("midreset in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    doOp(32'h3F00_0000, 32'h3F80_0000, "post reset", res);
    check("post reset const", res, 32'h3E80_0000);

    doOp(32'h1C80_0000, 32'h1C80_0000, "subnormal", res);
`ifdef SIGMOID_BWD_FTZ_EN
    check("subnormal const", res, 32'h0000_0000);
`else
    check("subnormal const", res, 32'h0000_0200);
`endif

    for (int i = 0; i < 24; i++) begin
      s = {1'b0, 8'($urandom_range(100, 126)), 23'($urandom)};
      g = {1'($urandom), 8'($urandom_range(90, 160)), 23'($urandom)};
      doOp(s, g, "random", res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
